// File: rtl/video_pkg.sv
// Shared types for the video timing sequencer: timing register set, register
// addresses, config FSM states and the commit-time clamp.
package video_pkg;

    typedef struct packed {
        logic [9:0] h_last;
        logic [9:0] h_act_lo;
        logic [9:0] h_act_hi;
        logic [9:0] h_sync;
        logic [8:0] v_last;
        logic [8:0] v_act_lo;
        logic [8:0] v_act_hi;
        logic [8:0] v_sync;
    } timing_cfg_t;

    localparam timing_cfg_t TIMING_DEFAULT = '{
        h_last:   10'd767,
        h_act_lo: 10'd20,
        h_act_hi: 10'd680,
        h_sync:   10'd707,
        v_last:   9'd311,
        v_act_lo: 9'd10,
        v_act_hi: 9'd306,
        v_sync:   9'd308
    };

    typedef enum logic [2:0] {
        REG_H_LAST   = 3'd0,
        REG_H_ACT_LO = 3'd1,
        REG_H_ACT_HI = 3'd2,
        REG_H_SYNC   = 3'd3,
        REG_V_LAST   = 3'd4,
        REG_V_ACT_LO = 3'd5,
        REG_V_ACT_HI = 3'd6,
        REG_V_SYNC   = 3'd7
    } cfg_addr_t;

    typedef enum logic {
        ST_RUN,
        ST_PEND
    } cfg_state_t;

    // A line or frame limit of 0 would stall the raster, so force at least 2 steps.
    function automatic timing_cfg_t clamp_cfg(input timing_cfg_t c);
        timing_cfg_t r;
        r = c;
        if (r.h_last == 10'd0) r.h_last = 10'd1;
        if (r.v_last == 9'd0)  r.v_last = 9'd1;
        return r;
    endfunction

endpackage

// File: rtl/video_timing_ctrl_if.sv
// Config register port of the video timing sequencer: write strobe, address,
// data, and the pending-commit status returned to the writer.
interface video_timing_ctrl_if;
    logic       cfg_wr;
    logic [2:0] cfg_addr;
    logic [9:0] cfg_data;
    logic       cfg_pending;

    modport master (output cfg_wr, output cfg_addr, output cfg_data, input cfg_pending);
    modport slave  (input cfg_wr, input cfg_addr, input cfg_data, output cfg_pending);
endinterface

// File: rtl/video_cfg_shadow.sv
// Shadow register bank with write decode; the whole set is committed to the
// live registers at frame end so a mode change never tears a frame.
module video_cfg_shadow
    import video_pkg::*;
#(
    parameter int H_LAST_D = 767,
    parameter int V_LAST_D = 311
) (
    input  logic         clk_pix,
    input  logic         reset,
    input  logic         fe,
    video_timing_ctrl_if.slave cfg,
    output timing_cfg_t  live
);

    localparam timing_cfg_t RESET_CFG = '{
        h_last:   10'(H_LAST_D),
        h_act_lo: TIMING_DEFAULT.h_act_lo,
        h_act_hi: TIMING_DEFAULT.h_act_hi,
        h_sync:   TIMING_DEFAULT.h_sync,
        v_last:   9'(V_LAST_D),
        v_act_lo: TIMING_DEFAULT.v_act_lo,
        v_act_hi: TIMING_DEFAULT.v_act_hi,
        v_sync:   TIMING_DEFAULT.v_sync
    };

    timing_cfg_t shadow;
    cfg_state_t  state, state_next;
    logic        commit;

    assign commit          = fe && (state == ST_PEND);
    assign cfg.cfg_pending = (state == ST_PEND);

    always_ff @(posedge clk_pix) begin
        if (reset) state <= ST_RUN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:  if (cfg.cfg_wr)         state_next = ST_PEND;
            ST_PEND: if (fe && !cfg.cfg_wr)  state_next = ST_RUN;
            default:                         state_next = ST_RUN;
        endcase
    end

    // NOTE: non-blocking updates mean a write coincident with the commit lands in
    // shadow after live has already sampled the pre-write value.
    always_ff @(posedge clk_pix) begin
        if (reset) begin
            shadow <= RESET_CFG;
            live   <= RESET_CFG;
        end else begin
            if (commit) live <= clamp_cfg(shadow);
            if (cfg.cfg_wr) begin
                case (cfg_addr_t'(cfg.cfg_addr))
                    REG_H_LAST:   shadow.h_last   <= cfg.cfg_data;
                    REG_H_ACT_LO: shadow.h_act_lo <= cfg.cfg_data;
                    REG_H_ACT_HI: shadow.h_act_hi <= cfg.cfg_data;
                    REG_H_SYNC:   shadow.h_sync   <= cfg.cfg_data;
                    REG_V_LAST:   shadow.v_last   <= cfg.cfg_data[8:0];
                    REG_V_ACT_LO: shadow.v_act_lo <= cfg.cfg_data[8:0];
                    REG_V_ACT_HI: shadow.v_act_hi <= cfg.cfg_data[8:0];
                    REG_V_SYNC:   shadow.v_sync   <= cfg.cfg_data[8:0];
                    default:      ;
                endcase
            end
        end
    end

endmodule

// File: rtl/video_timing_ctrl.sv
// Programmable raster timing sequencer: hc/vc counters, registered blank/sync/de
// flags, frame_start pulse and per-frame scroll phase for the background.
module video_timing_ctrl
    import video_pkg::*;
#(
    parameter int SCROLL_STEP = 6,
    parameter int H_LAST_D    = 767,
    parameter int V_LAST_D    = 311
) (
    input  logic        clk_pix,
    input  logic        reset,
    input  logic        ce_pix,
    video_timing_ctrl_if.slave cfg,
    output logic [9:0]  hc,
    output logic [8:0]  vc,
    output logic        hblank,
    output logic        vblank,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start,
    output logic [9:0]  scroll
);

    timing_cfg_t live;
    logic        h_end, v_end, fe;
    logic        hblank_c, vblank_c;

    assign h_end    = (hc == live.h_last);
    assign v_end    = (vc == live.v_last);
    assign fe       = ce_pix && h_end && v_end;
    assign hblank_c = (hc < live.h_act_lo) || (hc > live.h_act_hi);
    assign vblank_c = (vc < live.v_act_lo) || (vc > live.v_act_hi);

    video_cfg_shadow #(
        .H_LAST_D (H_LAST_D),
        .V_LAST_D (V_LAST_D)
    ) u_cfg_shadow (
        .clk_pix (clk_pix),
        .reset   (reset),
        .fe      (fe),
        .cfg     (cfg),
        .live    (live)
    );

    // Flags are sampled from the counter value being output, so they trail hc/vc
    // by one pixel enable.
    always_ff @(posedge clk_pix) begin
        if (reset) begin
            hc          <= '0;
            vc          <= '0;
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            de          <= 1'b0;
            frame_start <= 1'b0;
            scroll      <= '0;
        end else begin
            frame_start <= fe;
            if (ce_pix) begin
                hc <= h_end ? 10'd0 : hc + 10'd1;
                if (h_end) vc <= v_end ? 9'd0 : vc + 9'd1;
                hblank <= hblank_c;
                vblank <= vblank_c;
                hsync  <= (hc >= live.h_sync);
                vsync  <= (vc >= live.v_sync);
                de     <= !hblank_c && !vblank_c;
                if (h_end && v_end) scroll <= scroll + 10'(SCROLL_STEP);
            end
        end
    end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Directed bench for video_timing_ctrl; a short frame height keeps full-frame
// scenarios inside a small cycle budget.
module tb_video_timing_ctrl;

    localparam int VL = 3;   // frame height parameter: 4 lines per frame

    logic       clk_pix = 1'b0;
    logic       reset;
    logic       ce_pix;
    logic [9:0] hc;
    logic [8:0] vc;
    logic       hblank, vblank, hsync, vsync, de, frame_start;
    logic [9:0] scroll;

    int checks = 0;
    int errors = 0;
    int frames = 0;
    bit ph     = 1'b1;

    video_timing_ctrl_if cfg ();

    video_timing_ctrl #(
        .SCROLL_STEP (6),
        .H_LAST_D    (767),
        .V_LAST_D    (VL)
    ) dut (
        .clk_pix     (clk_pix),
        .reset       (reset),
        .ce_pix      (ce_pix),
        .cfg         (cfg),
        .hc          (hc),
        .vc          (vc),
        .hblank      (hblank),
        .vblank      (vblank),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .frame_start (frame_start),
        .scroll      (scroll)
    );

    always #5 clk_pix = ~clk_pix;

    // Inputs change at negedge; outputs are read at the following negedge.
    task automatic tick(input logic ce);
        ce_pix = ce;
        @(negedge clk_pix);
        cfg.cfg_wr = 1'b0;
        if (frame_start) frames++;
    endtask

    task automatic write_cfg(input logic [2:0] a, input logic [9:0] d, input logic ce);
        cfg.cfg_wr   = 1'b1;
        cfg.cfg_addr = a;
        cfg.cfg_data = d;
        tick(ce);
    endtask

    task automatic run_to_frame(input bit alt, input int limit,
                                output int cyc, output int max_hc, output bit ok);
        ok = 1'b0; cyc = 0; max_hc = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            tick(alt ? ph : 1'b1);
            if (alt) ph = ~ph;
            cyc++;
            if (frame_start) ok = 1'b1;
            else if (int'(hc) > max_hc) max_hc = int'(hc);
        end
    endtask

    task automatic test_reset();
        checks++; if (hc !== 10'd0)     begin errors++; $display("FAIL reset_hc got %0d want 0", hc); end
        checks++; if (vc !== 9'd0)      begin errors++; $display("FAIL reset_vc got %0d want 0", vc); end
        checks++; if (scroll !== 10'd0) begin errors++; $display("FAIL reset_scroll got %0d want 0", scroll); end
        checks++;
        if ({hblank, vblank, hsync, vsync, de, frame_start} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_flags got %b want 110000", {hblank, vblank, hsync, vsync, de, frame_start});
        end
        checks++; if (cfg.cfg_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", cfg.cfg_pending); end
    endtask

    // One default line with ce_pix every other cycle; flags describe the previous hc.
    task automatic test_default_line();
        int exp_h, old_h, bad_hc, bad_hs, bad_hb, rise_at, fall_at;
        exp_h = 0; bad_hc = 0; bad_hs = 0; bad_hb = 0; rise_at = -1; fall_at = -1;
        for (int k = 0; k < 768; k++) begin
            old_h = exp_h;
            tick(1'b1);
            exp_h = (old_h == 767) ? 0 : old_h + 1;
            if (hc !== 10'(exp_h))                           bad_hc++;
            if (hsync !== (old_h >= 707))                    bad_hs++;
            if (hblank !== (old_h < 20 || old_h > 680))      bad_hb++;
            if (hsync && rise_at < 0)                        rise_at = int'(hc);
            if (!hblank && fall_at < 0)                      fall_at = int'(hc);
            tick(1'b0);
            if (hc !== 10'(exp_h))                           bad_hc++;
        end
        checks++; if (bad_hc != 0) begin errors++; $display("FAIL line_hc mismatches %0d want 0", bad_hc); end
        checks++; if (bad_hs != 0) begin errors++; $display("FAIL line_hsync mismatches %0d want 0", bad_hs); end
        checks++; if (bad_hb != 0) begin errors++; $display("FAIL line_hblank mismatches %0d want 0", bad_hb); end
        checks++; if (rise_at != 708) begin errors++; $display("FAIL hsync_rise at hc %0d want 708", rise_at); end
        checks++; if (fall_at != 21)  begin errors++; $display("FAIL hblank_fall at hc %0d want 21", fall_at); end
        checks++; if (vc !== 9'd1)    begin errors++; $display("FAIL line_vc got %0d want 1", vc); end
    endtask

    task automatic test_frame_period();
        int cyc, mh; bit ok;
        ph = 1'b1;
        run_to_frame(1'b1, 7000, cyc, mh, ok);
        checks++; if (!ok) begin errors++; $display("FAIL first_frame timeout got 0 want 1"); end
        checks++; if (scroll !== 10'd6) begin errors++; $display("FAIL scroll_frame1 got %0d want 6", scroll); end
        checks++; if (hc !== 10'd0 || vc !== 9'd0) begin errors++; $display("FAIL fs_origin got %0d,%0d want 0,0", hc, vc); end
        run_to_frame(1'b1, 7000, cyc, mh, ok);
        checks++; if (cyc != 6144) begin errors++; $display("FAIL frame_period got %0d want 6144", cyc); end
        checks++; if (mh != 767)   begin errors++; $display("FAIL frame_max_hc got %0d want 767", mh); end
        checks++; if (scroll !== 10'd12) begin errors++; $display("FAIL scroll_frame2 got %0d want 12", scroll); end
    endtask

    task automatic test_mid_frame_write();
        int cyc, mh; bit ok;
        for (int i = 0; i < 100; i++) tick(1'b1);
        write_cfg(3'd0, 10'd639, 1'b0);
        checks++; if (cfg.cfg_pending !== 1'b1) begin errors++; $display("FAIL mid_pending got %b want 1", cfg.cfg_pending); end
        run_to_frame(1'b0, 4000, cyc, mh, ok);
        checks++; if (!ok || mh != 767) begin errors++; $display("FAIL mid_old_wrap got %0d want 767", mh); end
        checks++; if (cfg.cfg_pending !== 1'b0) begin errors++; $display("FAIL mid_committed got %b want 0", cfg.cfg_pending); end
        run_to_frame(1'b0, 4000, cyc, mh, ok);
        checks++; if (mh != 639)   begin errors++; $display("FAIL mid_new_wrap got %0d want 639", mh); end
        checks++; if (cyc != 2560) begin errors++; $display("FAIL mid_new_period got %0d want 2560", cyc); end
    endtask

    task automatic test_fe_coincident();
        int cyc, mh; bit ok, found;
        write_cfg(3'd4, 10'd2, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            if (hc == 10'd639 && vc == 9'd3) found = 1'b1;
            else tick(1'b1);
        end
        checks++; if (!found) begin errors++; $display("FAIL fe_search timeout got 0 want 1"); end
        write_cfg(3'd4, 10'd5, 1'b1);
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL fe_pulse got %b want 1", frame_start); end
        checks++; if (cfg.cfg_pending !== 1'b1) begin errors++; $display("FAIL fe_keep_pending got %b want 1", cfg.cfg_pending); end
        run_to_frame(1'b0, 5000, cyc, mh, ok);
        checks++; if (cyc != 1920) begin errors++; $display("FAIL fe_old_shadow period got %0d want 1920", cyc); end
        checks++; if (cfg.cfg_pending !== 1'b0) begin errors++; $display("FAIL fe_second_commit got %b want 0", cfg.cfg_pending); end
        run_to_frame(1'b0, 5000, cyc, mh, ok);
        checks++; if (cyc != 3840) begin errors++; $display("FAIL fe_new_period got %0d want 3840", cyc); end
    endtask

    task automatic test_clamp();
        int cyc, mh; bit ok;
        logic [9:0] exp_h [4] = '{10'd1, 10'd0, 10'd1, 10'd0};
        logic [8:0] exp_v [4] = '{9'd0, 9'd1, 9'd1, 9'd0};
        write_cfg(3'd0, 10'd0, 1'b0);
        write_cfg(3'd4, 10'd0, 1'b0);
        run_to_frame(1'b0, 5000, cyc, mh, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clamp_commit timeout got 0 want 1"); end
        for (int i = 0; i < 4; i++) begin
            tick(1'b1);
            checks++;
            if (hc !== exp_h[i] || vc !== exp_v[i]) begin
                errors++; $display("FAIL clamp_seq%0d got %0d,%0d want %0d,%0d", i, hc, vc, exp_h[i], exp_v[i]);
            end
        end
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL clamp_frame got %b want 1", frame_start); end
    endtask

    task automatic test_vflags();
        int cyc, mh, eh, ev, oh, ov, bad; bit ok;
        write_cfg(3'd1, 10'd0, 1'b0);
        write_cfg(3'd2, 10'd1, 1'b0);
        write_cfg(3'd3, 10'd1, 1'b0);
        write_cfg(3'd5, 10'd1, 1'b0);
        write_cfg(3'd6, 10'd1, 1'b0);
        write_cfg(3'd7, 10'd1, 1'b0);
        run_to_frame(1'b0, 20, cyc, mh, ok);
        checks++; if (!ok) begin errors++; $display("FAIL vflags_commit timeout got 0 want 1"); end
        eh = 0; ev = 0; bad = 0;
        for (int i = 0; i < 8; i++) begin
            oh = eh; ov = ev;
            tick(1'b1);
            eh = (oh == 1) ? 0 : 1;
            if (oh == 1) ev = (ov == 1) ? 0 : 1;
            if (hc !== 10'(eh) || vc !== 9'(ev)) bad++;
            if (hblank !== 1'b0 || hsync !== (oh >= 1)) bad++;
            if (vblank !== (ov != 1) || vsync !== (ov >= 1) || de !== (ov == 1)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL vflags mismatches %0d want 0", bad); end
    endtask

    task automatic test_scroll_wrap();
        for (int i = 0; i < 1000 && frames < 170; i++) tick(1'b1);
        checks++; if (scroll !== 10'd1020) begin errors++; $display("FAIL scroll_170 got %0d want 1020", scroll); end
        for (int i = 0; i < 10 && frames < 171; i++) tick(1'b1);
        checks++; if (scroll !== 10'd2) begin errors++; $display("FAIL scroll_wrap got %0d want 2", scroll); end
    endtask

    task automatic test_reset_pending();
        int cyc, mh; bit ok;
        write_cfg(3'd0, 10'd700, 1'b0);
        checks++; if (cfg.cfg_pending !== 1'b1) begin errors++; $display("FAIL rst_pre_pending got %b want 1", cfg.cfg_pending); end
        reset = 1'b1;
        tick(1'b1);
        test_reset();
        reset = 1'b0;
        frames = 0;
        for (int i = 0; i < 768; i++) tick(1'b1);
        checks++; if (hc !== 10'd0 || vc !== 9'd1) begin errors++; $display("FAIL rst_line got %0d,%0d want 0,1", hc, vc); end
        run_to_frame(1'b0, 4000, cyc, mh, ok);
        checks++; if (cyc != 2304 || mh != 767) begin errors++; $display("FAIL rst_frame got %0d/%0d want 2304/767", cyc, mh); end
        checks++; if (scroll !== 10'd6) begin errors++; $display("FAIL rst_scroll got %0d want 6", scroll); end
    endtask

    initial begin
        reset        = 1'b1;
        ce_pix       = 1'b0;
        cfg.cfg_wr   = 1'b0;
        cfg.cfg_addr = 3'd0;
        cfg.cfg_data = 10'd0;
        @(negedge clk_pix);
        tick(1'b0);
        tick(1'b1);
        test_reset();
        reset = 1'b0;
        test_default_line();
        test_frame_period();
        test_mid_frame_write();
        test_fe_coincident();
        test_clamp();
        test_vflags();
        test_scroll_wrap();
        test_reset_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
